// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and stall controller for a 5-stage F/D/E/M/W core. It drives the stall, bubble and
// flush enables of every pipeline register. The inputs are:
//   - the Decode source register ids,
//   - the destination of a load sitting in E,
//   - the taken-branch resolution in Decode,
//   - the instruction-bus and data-bus wait handshakes.
//
// A taken branch that resolves while a fetch is still outstanding is remembered in redir_pend.
// The wrong-path instruction is discarded when that fetch returns.
//
// Optional feature macro: PIPE_CTRL_PERF_EN. When it is defined, the block builds three perf
// counters. When it is not defined, the counter outputs are tied to 0.
//
// Ports
//   clk, reset                      clock; synchronous active-high reset
//   d_src_a/_use, d_src_b/_use      Decode source register ids and their read-enables
//   e_dst_m                         destination of the load in E (0 = no load)
//   d_br_taken                      Decode resolved a taken branch
//   i_wait, m_wait                  fetch outstanding / M-stage data access outstanding
//   stall_f/d/e/m                   hold the PC/F, D, E and M registers
//   flush_d, bubble_e, bubble_w     load a bubble into the D, E and W registers
//   redirect_f                      PC takes the branch target this cycle
//   redir_pend                      a redirect is waiting for the outstanding fetch
//   lu_cnt, mem_cnt, redir_cnt      perf counters (load-use, memory wait, redirect)
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] d_src_a,
  input  logic             d_src_a_use,
  input  logic [REG_W-1:0] d_src_b,
  input  logic             d_src_b_use,
  input  logic [REG_W-1:0] e_dst_m,
  input  logic             d_br_taken,
  input  logic             i_wait,
  input  logic             m_wait,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             bubble_e,
  output logic             bubble_w,
  output logic             redirect_f,
  output logic             redir_pend,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mem_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MWAIT   = 2'd1,
    ST_LUSTALL = 2'd2,
    ST_IREDIR  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_redir_pend;
  logic   w_load_use;
  logic   w_lu_eff;
  logic   w_set_pend;
  logic   w_clr_pend;

  // Load-use hazard detection. R0 never hazards.
  // The cycle right after a bubble is exempt, so each load costs at most one bubble.
  always_comb begin
    w_load_use = (e_dst_m != {REG_W{1'b0}}) &&
                 ((d_src_a_use && (d_src_a == e_dst_m)) ||
                  (d_src_b_use && (d_src_b == e_dst_m)));
    w_lu_eff   = w_load_use && (r_state != ST_LUSTALL);
  end

  // Prioritised pipeline-enable generation. Every output is forced to 0 while reset is high.
  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    bubble_e   = 1'b0;
    bubble_w   = 1'b0;
    redirect_f = 1'b0;
    w_set_pend = 1'b0;
    w_clr_pend = 1'b0;
    if (reset) begin
      w_clr_pend = 1'b0;
    end else if (m_wait) begin
      // Freeze the whole front of the pipe. W receives a bubble.
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_e  = 1'b1;
      stall_m  = 1'b1;
      bubble_w = 1'b1;
    end else if (r_redir_pend && !i_wait) begin
      // The wrong-path fetch has returned. Redirect the PC and drop the returned instruction.
      redirect_f = 1'b1;
      flush_d    = 1'b1;
      w_clr_pend = 1'b1;
    end else if (w_lu_eff) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      bubble_e = 1'b1;
    end else if (d_br_taken) begin
      flush_d = 1'b1;
      if (i_wait) begin
        stall_f    = 1'b1;
        w_set_pend = 1'b1;
      end else begin
        redirect_f = 1'b1;
      end
    end else if (i_wait) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
    end else begin
      w_clr_pend = 1'b0;
    end
  end

  // Next-state selection. IREDIR tracks a pending redirect across memory waits.
  always_comb begin
    w_state_nxt = ST_RUN;
    if (m_wait) begin
      w_state_nxt = r_redir_pend ? ST_IREDIR : ST_MWAIT;
    end else if (r_redir_pend) begin
      w_state_nxt = i_wait ? ST_IREDIR : ST_RUN;
    end else if (w_lu_eff) begin
      w_state_nxt = ST_LUSTALL;
    end else if (d_br_taken && i_wait) begin
      w_state_nxt = ST_IREDIR;
    end else begin
      w_state_nxt = ST_RUN;
    end
  end

  // State register and pending-redirect flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_redir_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_set_pend) begin
        r_redir_pend <= 1'b1;
      end else if (w_clr_pend) begin
        r_redir_pend <= 1'b0;
      end else begin
        r_redir_pend <= r_redir_pend;
      end
    end
  end

  assign redir_pend = r_redir_pend && !reset;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_mem_cnt;
  logic [CNT_W-1:0] r_redir_cnt;
  logic             w_mem_stall;

  // A memory-wait cycle is either a full freeze (stall_m set) or an F stall without a
  // load-use bubble. The second case can only be caused by i_wait.
  assign w_mem_stall = stall_m || (stall_f && !bubble_e);

  // Perf counters. They wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lu_cnt    <= {CNT_W{1'b0}};
      r_mem_cnt   <= {CNT_W{1'b0}};
      r_redir_cnt <= {CNT_W{1'b0}};
    end else begin
      r_lu_cnt    <= r_lu_cnt + {{(CNT_W-1){1'b0}}, bubble_e};
      r_mem_cnt   <= r_mem_cnt + {{(CNT_W-1){1'b0}}, w_mem_stall};
      r_redir_cnt <= r_redir_cnt + {{(CNT_W-1){1'b0}}, redirect_f};
    end
  end

  assign lu_cnt    = r_lu_cnt;
  assign mem_cnt   = r_mem_cnt;
  assign redir_cnt = r_redir_cnt;
`else
  assign lu_cnt    = {CNT_W{1'b0}};
  assign mem_cnt   = {CNT_W{1'b0}};
  assign redir_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. It runs three kinds of stimulus:
//   - a table of single-cycle vectors applied from reset,
//   - hand-written multi-cycle sequences,
//   - randomized traffic checked against a rule-level reference model.
// Output vector bit order: {stall_f, stall_d, stall_e, stall_m, flush_d, bubble_e, bubble_w,
// redirect_f, redir_pend}.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  localparam logic [8:0] E_IDLE = 9'b000000000;
  localparam logic [8:0] E_MW   = 9'b111100100;
  localparam logic [8:0] E_LU   = 9'b110001000;
  localparam logic [8:0] E_RED  = 9'b000010010;
  localparam logic [8:0] E_IW   = 9'b100010000;
  localparam logic [8:0] E_PEND = 9'b000000001;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] d_src_a, d_src_b, e_dst_m;
  logic             d_src_a_use, d_src_b_use, d_br_taken, i_wait, m_wait;
  logic             stall_f, stall_d, stall_e, stall_m, flush_d, bubble_e, bubble_w;
  logic             redirect_f, redir_pend;
  logic [CNT_W-1:0] lu_cnt, mem_cnt, redir_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .d_src_a(d_src_a), .d_src_a_use(d_src_a_use),
    .d_src_b(d_src_b), .d_src_b_use(d_src_b_use),
    .e_dst_m(e_dst_m), .d_br_taken(d_br_taken), .i_wait(i_wait), .m_wait(m_wait),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .bubble_e(bubble_e), .bubble_w(bubble_w),
    .redirect_f(redirect_f), .redir_pend(redir_pend),
    .lu_cnt(lu_cnt), .mem_cnt(mem_cnt), .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] a;
    logic       au;
    logic [4:0] b;
    logic       bu;
    logic [4:0] e;
    logic       br;
    logic       iw;
    logic       mw;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [8:0] outs();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, bubble_e, bubble_w,
            redirect_f, redir_pend};
  endfunction

  task automatic chk(input string nm, input logic [8:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, outs(), exp);
    end
  endtask

  task automatic chk_val(input string nm, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge. Check the outputs before the next rising edge.
  task automatic step(input string nm, input logic [4:0] a, input logic au, input logic [4:0] b,
                      input logic bu, input logic [4:0] e, input logic br, input logic iw,
                      input logic mw, input logic [8:0] exp);
    @(negedge clk);
    d_src_a = a; d_src_a_use = au; d_src_b = b; d_src_b_use = bu;
    e_dst_m = e; d_br_taken = br; i_wait = iw; m_wait = mw;
    #2;
    chk(nm, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    d_src_a = 5'd0; d_src_a_use = 1'b0; d_src_b = 5'd0; d_src_b_use = 1'b0;
    e_dst_m = 5'd0; d_br_taken = 1'b0; i_wait = 1'b0; m_wait = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference-model state: a pending redirect, and whether the last cycle inserted a load-use bubble.
  logic       m_pend, m_last_lu, lu, fire;
  logic [8:0] m_exp;
  logic [4:0] ra, rb, re;
  logic       rau, rbu, rbr, riw, rmw;
  logic [CNT_W-1:0] c_lu, c_mem, c_red;

  initial begin
    reset = 1'b1;
    d_src_a = 5'd0; d_src_a_use = 1'b0; d_src_b = 5'd0; d_src_b_use = 1'b0;
    e_dst_m = 5'd0; d_br_taken = 1'b0; i_wait = 1'b0; m_wait = 1'b0;

    vecs[0]  = '{"idle",        5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE};
    vecs[1]  = '{"lu_src_b",    5'd1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, E_LU};
    vecs[2]  = '{"lu_src_a",    5'd7, 1'b1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_LU};
    vecs[3]  = '{"r0_no_haz",   5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE};
    vecs[4]  = '{"unused_a",    5'd5, 1'b0, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_IDLE};
    vecs[5]  = '{"unused_b",    5'd6, 1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, E_IDLE};
    vecs[6]  = '{"br_idle",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, E_RED};
    vecs[7]  = '{"br_iwait",    5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_IW};
    vecs[8]  = '{"iwait",       5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_IW};
    vecs[9]  = '{"mw_over_all", 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, E_MW};
    vecs[10] = '{"lu_over_br",  5'd2, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, E_LU};
    vecs[11] = '{"lu_over_iw",  5'd0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, E_LU};
    vecs[12] = '{"mw_only",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, E_MW};

    do_reset();
    #2;
    chk("reset_state", E_IDLE);
    for (int i = 0; i < 13; i++) begin
      do_reset();
      step(vecs[i].name, vecs[i].a, vecs[i].au, vecs[i].b, vecs[i].bu, vecs[i].e,
           vecs[i].br, vecs[i].iw, vecs[i].mw, vecs[i].exp);
    end

    // A taken branch while the fetch is outstanding: the redirect fires when the fetch returns.
    do_reset();
    step("bp_c0",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_IW);
    step("bp_c1",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_IW | E_PEND);
    step("bp_c2",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_IW | E_PEND);
    step("bp_mw",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, E_MW | E_PEND);
    step("bp_fire", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RED | E_PEND);
    step("bp_done", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE);

    // m_wait held for 4 cycles over a load-use: 4 freezes, then exactly one bubble.
    do_reset();
    for (int i = 0; i < 4; i++) step("mwlu_freeze", 5'd0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, E_MW);
    step("mwlu_bubble", 5'd0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, E_LU);
    step("mwlu_once",   5'd0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, E_IDLE);

    // Reset asserted with a pending redirect drops the pending redirect.
    do_reset();
    step("rp_set", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_IW);
    @(negedge clk);
    reset = 1'b1;
    d_br_taken = 1'b0;
    #2;
    chk("rp_during_reset", E_IDLE);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rp_after_reset", E_IW);
    step("rp_no_fire", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE);

    // Randomized traffic checked against the rule-level model.
    do_reset();
    m_pend = 1'b0; m_last_lu = 1'b0;
    c_lu = '0; c_mem = '0; c_red = '0;
    for (int n = 0; n < 400; n++) begin
      ra  = 5'($urandom_range(0, 3)); rau = 1'($urandom_range(0, 1));
      rb  = 5'($urandom_range(0, 3)); rbu = 1'($urandom_range(0, 1));
      re  = 5'($urandom_range(0, 3));
      rbr = ($urandom_range(0, 3) == 0);
      riw = ($urandom_range(0, 2) == 0);
      rmw = ($urandom_range(0, 4) == 0);
      if (m_pend) begin
        rbr = 1'b0; rau = 1'b0; rbu = 1'b0;
      end
      if (m_last_lu) re = 5'd0;
      lu   = (re != 5'd0) && ((rau && ra == re) || (rbu && rb == re)) && !m_last_lu;
      fire = m_pend && !riw && !rmw;
      if (rmw)            m_exp = E_MW;
      else if (fire)      m_exp = E_RED;
      else if (lu)        m_exp = E_LU;
      else if (rbr)       m_exp = riw ? E_IW : E_RED;
      else if (riw)       m_exp = E_IW;
      else                m_exp = E_IDLE;
      m_exp[0] = m_pend;
      step("random", ra, rau, rb, rbu, re, rbr, riw, rmw, m_exp);
      if (m_exp[5:1] == E_LU[5:1]) c_lu = c_lu + 1;
      if (rmw || (m_exp[8] && !m_exp[3])) c_mem = c_mem + 1;
      if (m_exp[1]) c_red = c_red + 1;
      m_last_lu = !rmw && !fire && lu;
      if (m_pend) m_pend = !fire;
      else        m_pend = !rmw && !lu && rbr && riw;
    end
    @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
    chk_val("lu_cnt", lu_cnt, c_lu);
    chk_val("mem_cnt", mem_cnt, c_mem);
    chk_val("redir_cnt", redir_cnt, c_red);
`else
    chk_val("lu_cnt", lu_cnt, '0);
    chk_val("mem_cnt", mem_cnt, '0);
    chk_val("redir_cnt", redir_cnt, '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
